osd_cmd_sequencer: RTL and testbench
====================================

# osd_cmd_sequencer

Turns one-shot operator commands (OSD triggers and keyboard hotkeys for coin, start 1, start 2, game reset) into timed, non-overlapping active-low pulses for the arcade core. Sits between `hps_io`/keyboard decode and `target_top`. Requests are queued and granted one at a time by fixed priority. Each pulse is stretched long enough for the game CPU's input polling to see it.

## Interface
- `CLK_KHZ`, 50000: `clk` frequency in kHz; sets the 1 ms prescaler.
- `PULSE_MS`, 100: coin/start pulse length, ms.
- `GAP_MS`, 50: mandatory all-inactive gap after every pulse, ms.
- `RESET_MS`, 20: game reset pulse length, ms.
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous active-low reset.
- `req_osd` in 4: OSD trigger levels, index 0 coin, 1 start1, 2 start2, 3 reset.
- `req_kbd` in 4: keyboard hotkey levels, same indexing.
- `coin_n` out 1: active-low coin.
- `start1_n` out 1: active-low start player 1.
- `start2_n` out 1: active-low start player 2.
- `game_rst_n` out 1: active-low reset to the game core.
- `busy` out 1: high in any state except IDLE.
- `pend` out 4: pending request bits.

Clock `clk`, reset `rst_n`: one clock; reset is asynchronous and active-low.

## Operation
- Edge detect:
  - Register `req_osd | req_kbd` once.
  - A rising edge (current high, registered low) sets the matching `pend` bit.
  - Levels held high produce exactly one request.
- Pending is a set, not a counter. Duplicate requests merge. If a set and a clear hit the same bit in the same cycle, the set wins.
- Priority: reset(3) > coin(0) > start1(1) > start2(2).
- States:
  - POR: entered on `rst_n` low. `game_rst_n`=0. Lasts RESET_MS after release, then GAP.
  - IDLE: all outputs inactive. If any `pend` bit is set, grant the highest-priority bit, clear it, and go to ACTIVE.
  - ACTIVE: drive only the granted output low. Lasts PULSE_MS, or RESET_MS for reset, then GAP.
  - GAP: all outputs inactive for GAP_MS, then IDLE.
- A reset grant also clears `pend[2:0]`. Coin/start requests that arrive during a reset pulse are still recorded.
- Timer:
  - Prescaler and ms counter are cleared on every state entry.
  - A duration of N ms is exactly N*CLK_KHZ cycles.
  - A parameter value of 0 is treated as 1.
- Reset values: `coin_n`=1, `start1_n`=1, `start2_n`=1, `game_rst_n`=0, `busy`=1, `pend`=0, state POR, edge register 0.
- `rst_n` asserted mid-pulse: all outputs go to their reset values immediately (asynchronous), and pending requests are lost.

## Timing
- All outputs are registered.
- Request high at edge k, with the previous sample low: `pend` bit set after edge k.
- If the FSM was in IDLE at edge k+1: state becomes ACTIVE and the output goes low after edge k+1. Request-to-pulse latency is 2 cycles.
- Output low for exactly duration×CLK_KHZ cycles, followed by GAP_MS×CLK_KHZ cycles all inactive.
- IDLE lasts at least 1 cycle between GAP and the next ACTIVE.
- Back-to-back pulse spacing is therefore (PULSE_MS+GAP_MS)×CLK_KHZ+1 cycles.
- `busy` falls in the same cycle the FSM enters IDLE.

## Structure
- Shared package `n1942_ctrl_pkg` holds:
  - `state_t` enum: POR, IDLE, ACTIVE, GAP.
  - Request index localparams: REQ_COIN=0, REQ_START1=1, REQ_START2=2, REQ_RESET=3.
  - `req_t` as a 4-bit vector.
- Sub-module `ms_timer`:
  - Contains the prescaler, the ms counter, and a synchronous `restart` input.
  - Inputs: `restart`, `len_ms`. Output: `done`, a one-cycle strobe.
- The top of the block holds the edge detect, pending set, priority encoder and FSM.

## Test plan
All scenarios use CLK_KHZ=4, PULSE_MS=3, GAP_MS=2, RESET_MS=1.

- Release `rst_n` → `game_rst_n`=0 for 4 cycles, then 8 GAP cycles, then IDLE with `busy`=0 and all outputs 1.
- From IDLE, pulse `req_osd[0]` high for 1 cycle → `coin_n` low 2 cycles later, for exactly 12 cycles; then 8 cycles all inactive; `pend`=0.
- `req_osd[1]` and `req_kbd[0]` rise in the same cycle → coin pulses first (12 cycles), 8-cycle gap, 1 IDLE cycle, then `start1_n` pulses for 12 cycles.
- During a coin pulse, raise `req_kbd[0]` three separate times → exactly one extra coin pulse follows.
- `pend` = coin+start2, then a reset request arrives → `game_rst_n` low for 4 cycles, `pend`=0 after the grant, no coin/start pulse follows.
- Hold `req_osd[2]` high for 100 cycles → exactly one `start2_n` pulse. Assert `rst_n` mid-pulse → `start2_n`=1 and `game_rst_n`=0 in the same cycle, with no clock edge needed.

Source files
------------

// File: rtl/n1942_ctrl_pkg.sv
// Shared types and helpers for the 1942 operator-control path:
// FSM state encoding, request bit positions and the grant priority order.
package n1942_ctrl_pkg;

  typedef enum logic [1:0] {
    POR    = 2'd0,
    IDLE   = 2'd1,
    ACTIVE = 2'd2,
    GAP    = 2'd3
  } state_t;

  localparam int REQ_COIN   = 0;
  localparam int REQ_START1 = 1;
  localparam int REQ_START2 = 2;
  localparam int REQ_RESET  = 3;

  typedef logic [3:0] req_t;

  // A duration of zero would make a state last forever or not at all,
  // so zero is promoted to the shortest meaningful length.
  function automatic int eff_ms(input int v);
    return (v < 1) ? 1 : v;
  endfunction

  // Highest-priority pending request: reset, then coin, start1, start2.
  // Caller guarantees at least one bit is set.
  function automatic logic [1:0] pick_req(input req_t r);
    if (r[REQ_RESET])
      return 2'(REQ_RESET);
    else if (r[REQ_COIN])
      return 2'(REQ_COIN);
    else if (r[REQ_START1])
      return 2'(REQ_START1);
    else
      return 2'(REQ_START2);
  endfunction

endpackage

// File: rtl/ms_timer.sv
// Millisecond interval timer: a clk-cycle prescaler feeding a ms counter.
// done strobes for one cycle at the last cycle of each len_ms interval, so
// an interval started by restart lasts exactly len_ms*CLK_KHZ cycles.
module ms_timer
  import n1942_ctrl_pkg::*;
#(
  parameter int CLK_KHZ = 50000,
  parameter int MS_W    = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            restart,
  input  logic [MS_W-1:0] len_ms,
  output logic            done
);

  localparam int KHZ = eff_ms(CLK_KHZ);
  localparam int PRE_W = $clog2(KHZ + 1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(KHZ - 1);

  logic [PRE_W-1:0] r_pre;
  logic [MS_W-1:0]  r_ms;
  logic [MS_W-1:0]  w_last_ms;
  logic             w_tick;

  assign w_last_ms = (len_ms == '0) ? '0 : (len_ms - MS_W'(1));
  assign w_tick    = (r_pre == PRE_LAST);
  assign done      = w_tick && (r_ms >= w_last_ms);

  // Prescaler and ms counter; both return to zero on restart so the first
  // cycle after restart is cycle 0 of the new interval.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre <= '0;
      r_ms  <= '0;
    end else if (restart) begin
      r_pre <= '0;
      r_ms  <= '0;
    end else if (w_tick) begin
      r_pre <= '0;
      r_ms  <= (r_ms >= w_last_ms) ? '0 : (r_ms + MS_W'(1));
    end else begin
      r_pre <= r_pre + PRE_W'(1);
    end
  end

endmodule

// File: rtl/osd_cmd_sequencer.sv
// Turns one-shot OSD/keyboard commands into timed, non-overlapping
// active-low pulses for the arcade core. Rising edges are latched into a
// pending set, granted one at a time by fixed priority, stretched to a
// fixed length and followed by a mandatory all-inactive gap.
module osd_cmd_sequencer
  import n1942_ctrl_pkg::*;
#(
  parameter int CLK_KHZ  = 50000,
  parameter int PULSE_MS = 100,
  parameter int GAP_MS   = 50,
  parameter int RESET_MS = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req_osd,
  input  logic [3:0] req_kbd,
  output logic       coin_n,
  output logic       start1_n,
  output logic       start2_n,
  output logic       game_rst_n,
  output logic       busy,
  output logic [3:0] pend
);

  localparam int MS_W = 16;
  localparam logic [MS_W-1:0] PULSE_LEN = MS_W'(eff_ms(PULSE_MS));
  localparam logic [MS_W-1:0] GAP_LEN   = MS_W'(eff_ms(GAP_MS));
  localparam logic [MS_W-1:0] RESET_LEN = MS_W'(eff_ms(RESET_MS));
  localparam req_t ALL_REQ = 4'hF;
  localparam req_t ONE_REQ = 4'h1;

  req_t       w_req;
  req_t       w_rise;
  req_t       w_clr;
  req_t       r_req_q;
  req_t       r_pend;
  state_t     r_state;
  state_t     w_state_nxt;
  logic [1:0] r_grant;
  logic [1:0] w_grant_nxt;
  logic       w_restart;
  logic       w_done;
  logic [MS_W-1:0] w_len;
  logic       r_coin_n;
  logic       r_start1_n;
  logic       r_start2_n;
  logic       r_game_rst_n;
  logic       r_busy;

  assign w_req  = req_osd | req_kbd;
  assign w_rise = w_req & ~r_req_q;

  // One-cycle-old copy of the merged request levels for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_req_q <= '0;
    else
      r_req_q <= w_req;
  end

  // Pending set: new rising edges are OR-ed in after the grant clear, so a
  // request arriving on the grant cycle survives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_pend <= '0;
    else
      r_pend <= (r_pend & ~w_clr) | w_rise;
  end

  // Length of the interval currently being timed; IDLE does not care.
  always_comb begin
    w_len = GAP_LEN;
    case (r_state)
      POR:     w_len = RESET_LEN;
      ACTIVE:  w_len = (r_grant == 2'(REQ_RESET)) ? RESET_LEN : PULSE_LEN;
      GAP:     w_len = GAP_LEN;
      default: w_len = GAP_LEN;
    endcase
  end

  // Every state change starts a fresh interval.
  assign w_restart = (w_state_nxt != r_state);

  ms_timer #(
    .CLK_KHZ (CLK_KHZ),
    .MS_W    (MS_W)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (w_restart),
    .len_ms  (w_len),
    .done    (w_done)
  );

  // Sequencing decisions: grant from IDLE, leave timed states on done.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_clr       = '0;
    case (r_state)
      POR: begin
        if (w_done)
          w_state_nxt = GAP;
      end
      IDLE: begin
        if (|r_pend) begin
          w_state_nxt = ACTIVE;
          w_grant_nxt = pick_req(r_pend);
          if (w_grant_nxt == 2'(REQ_RESET))
            w_clr = ALL_REQ;
          else
            w_clr = ONE_REQ << w_grant_nxt;
        end
      end
      ACTIVE: begin
        if (w_done)
          w_state_nxt = GAP;
      end
      GAP: begin
        if (w_done)
          w_state_nxt = IDLE;
      end
      default: w_state_nxt = POR;
    endcase
  end

  // State and granted request index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= POR;
      r_grant <= 2'(REQ_COIN);
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
    end
  end

  // Outputs are registered from the next state so they change on the same
  // edge as the state itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_coin_n     <= 1'b1;
      r_start1_n   <= 1'b1;
      r_start2_n   <= 1'b1;
      r_game_rst_n <= 1'b0;
      r_busy       <= 1'b1;
    end else begin
      r_coin_n     <= !((w_state_nxt == ACTIVE) && (w_grant_nxt == 2'(REQ_COIN)));
      r_start1_n   <= !((w_state_nxt == ACTIVE) && (w_grant_nxt == 2'(REQ_START1)));
      r_start2_n   <= !((w_state_nxt == ACTIVE) && (w_grant_nxt == 2'(REQ_START2)));
      r_game_rst_n <= !((w_state_nxt == POR) ||
                        ((w_state_nxt == ACTIVE) && (w_grant_nxt == 2'(REQ_RESET))));
      r_busy       <= (w_state_nxt != IDLE);
    end
  end

  assign coin_n     = r_coin_n;
  assign start1_n   = r_start1_n;
  assign start2_n   = r_start2_n;
  assign game_rst_n = r_game_rst_n;
  assign busy       = r_busy;
  assign pend       = r_pend;

endmodule

// File: tb/tb_osd_cmd_sequencer.sv
// Bench for osd_cmd_sequencer: directed scenarios followed by random request
// traffic and random asynchronous resets, all compared every cycle against
// a countdown-based behavioural model of the pulse schedule.
module tb_osd_cmd_sequencer;

  localparam int K = 4;
  localparam int P = 3;
  localparam int G = 2;
  localparam int R = 1;

  localparam int PH_RESET = 0;
  localparam int PH_IDLE  = 1;
  localparam int PH_PULSE = 2;
  localparam int PH_GAP   = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req_osd = 4'h0;
  logic [3:0] req_kbd = 4'h0;
  logic       coin_n;
  logic       start1_n;
  logic       start2_n;
  logic       game_rst_n;
  logic       busy;
  logic [3:0] pend;

  int errCount = 0;
  int checkCount = 0;

  int         mPhase;
  int         mLeft;
  int         mWhich;
  logic [3:0] mPend;
  logic [3:0] mPrev;

  osd_cmd_sequencer #(
    .CLK_KHZ  (K),
    .PULSE_MS (P),
    .GAP_MS   (G),
    .RESET_MS (R)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_osd    (req_osd),
    .req_kbd    (req_kbd),
    .coin_n     (coin_n),
    .start1_n   (start1_n),
    .start2_n   (start2_n),
    .game_rst_n (game_rst_n),
    .busy       (busy),
    .pend       (pend)
  );

  // Free-running 10-time-unit clock.
  always #5 clk = ~clk;

  // Single comparison point for every check in the bench.
  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checkCount++;
    if (obs !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Order in which waiting requests are served.
  function automatic int highestReq(input logic [3:0] p);
    int order [4];
    order = '{3, 0, 1, 2};
    for (int i = 0; i < 4; i++)
      if (p[order[i]]) return order[i];
    return 0;
  endfunction

  task automatic modelReset();
    mPhase = PH_RESET;
    mLeft  = R * K;
    mWhich = 0;
    mPend  = 4'h0;
    mPrev  = 4'h0;
  endtask

  // Advance the model by one clock edge given the merged request levels.
  task automatic modelStep(input logic [3:0] req);
    logic [3:0] rise;
    logic [3:0] clr;
    logic [3:0] one;
    one  = 4'b0001;
    rise = req & ~mPrev;
    clr  = 4'h0;
    if (mPhase == PH_IDLE) begin
      if (mPend != 4'h0) begin
        mWhich = highestReq(mPend);
        clr    = (mWhich == 3) ? 4'hF : (one << mWhich);
        mPhase = PH_PULSE;
        mLeft  = ((mWhich == 3) ? R : P) * K;
      end
    end else begin
      mLeft--;
      if (mLeft == 0) begin
        if (mPhase == PH_GAP) begin
          mPhase = PH_IDLE;
        end else begin
          mPhase = PH_GAP;
          mLeft  = G * K;
        end
      end
    end
    mPend = (mPend & ~clr) | rise;
    mPrev = req;
  endtask

  task automatic checkAll();
    logic eCoin, eS1, eS2, eRst, eBusy;
    eCoin = !(mPhase == PH_PULSE && mWhich == 0);
    eS1   = !(mPhase == PH_PULSE && mWhich == 1);
    eS2   = !(mPhase == PH_PULSE && mWhich == 2);
    eRst  = !(mPhase == PH_RESET || (mPhase == PH_PULSE && mWhich == 3));
    eBusy = (mPhase != PH_IDLE);
    checkOutput("coin_n",     8'(coin_n),     8'(eCoin));
    checkOutput("start1_n",   8'(start1_n),   8'(eS1));
    checkOutput("start2_n",   8'(start2_n),   8'(eS2));
    checkOutput("game_rst_n", 8'(game_rst_n), 8'(eRst));
    checkOutput("busy",       8'(busy),       8'(eBusy));
    checkOutput("pend",       8'(pend),       8'(mPend));
  endtask

  // Drive one cycle of request levels, then check outputs mid-cycle.
  task automatic applyStimulus(input logic [3:0] osd, input logic [3:0] kbd);
    req_osd = osd;
    req_kbd = kbd;
    @(posedge clk);
    if (rst_n) modelStep(osd | kbd);
    @(negedge clk);
    checkAll();
  endtask

  // Pull rst_n low between edges and confirm the outputs react at once.
  task automatic asyncReset();
    #2;
    rst_n = 1'b0;
    #1;
    modelReset();
    checkAll();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] curO;
    logic [3:0] curK;
    modelReset();
    repeat (2) @(negedge clk);
    checkAll();
    rst_n = 1'b1;

    // Power-on sequence into IDLE.
    repeat (14) applyStimulus(4'h0, 4'h0);

    // Single coin request.
    applyStimulus(4'h1, 4'h0);
    repeat (25) applyStimulus(4'h0, 4'h0);

    // Start1 and coin together; coin wins.
    applyStimulus(4'h2, 4'h1);
    repeat (45) applyStimulus(4'h0, 4'h0);

    // Repeated coin hotkey during a coin pulse merges into one request.
    applyStimulus(4'h1, 4'h0);
    repeat (3) begin
      applyStimulus(4'h0, 4'h0);
      applyStimulus(4'h0, 4'h1);
    end
    repeat (50) applyStimulus(4'h0, 4'h0);

    // Coin and start2 pending behind a start1 pulse, then a reset request.
    applyStimulus(4'h2, 4'h0);
    repeat (2) applyStimulus(4'h0, 4'h0);
    applyStimulus(4'h5, 4'h0);
    applyStimulus(4'h0, 4'h0);
    applyStimulus(4'h8, 4'h0);
    repeat (60) applyStimulus(4'h0, 4'h0);

    // Held start2 level gives a single pulse.
    repeat (100) applyStimulus(4'h4, 4'h0);
    repeat (20) applyStimulus(4'h0, 4'h0);

    // Reset in the middle of a start2 pulse.
    repeat (6) applyStimulus(4'h4, 4'h0);
    asyncReset();
    repeat (20) applyStimulus(4'h0, 4'h0);

    // Random traffic with occasional asynchronous resets.
    curO = 4'h0;
    curK = 4'h0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0) curO = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) curK = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) != 0) curO = curO & 4'($urandom_range(0, 15));
      applyStimulus(curO, curK);
      if ($urandom_range(0, 499) == 0) asyncReset();
    end

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
